// File: rtl/core_pkg.sv
// Shared core definitions: control bundle layout used by decode, issue and execute.
package core_pkg;

    localparam int CTRL_W     = 8;
    localparam int REG_IDX_W  = 5;

    // Bit positions inside the control bundle
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_HI = 7;

    // A bubble carries no side effects at all
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CTRL_W-1:0]    ctrl_t;

    // True when the write-back port is writing the register being read
    function automatic logic wb_hits(input logic wb_regwrite, input reg_idx_t wb_rd,
                                     input reg_idx_t rs);
        return wb_regwrite && (wb_rd != '0) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_issue_if.sv
// Decode/write-back inputs and execute-side outputs of the issue stage.
interface id_ex_issue_if #(parameter int n = 32);
    import core_pkg::*;

    logic           id_valid;
    logic [n-1:0]   id_pc;
    reg_idx_t       id_rs1;
    reg_idx_t       id_rs2;
    reg_idx_t       id_rd;
    logic [n-1:0]   id_rs1_data;
    logic [n-1:0]   id_rs2_data;
    logic [n-1:0]   id_imm;
    ctrl_t          id_ctrl;
    logic           wb_regwrite;
    reg_idx_t       wb_rd;
    logic [n-1:0]   wb_data;
    logic           flush;

    logic           stall;
    logic           ex_valid;
    logic [n-1:0]   ex_pc;
    logic [n-1:0]   ex_rs1_data;
    logic [n-1:0]   ex_rs2_data;
    logic [n-1:0]   ex_imm;
    reg_idx_t       ex_rs1;
    reg_idx_t       ex_rs2;
    reg_idx_t       ex_rd;
    ctrl_t          ex_ctrl;
    logic [31:0]    bubble_count;

    // Upstream side: decode, write-back and branch redirect
    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_ctrl, wb_regwrite, wb_rd, wb_data, flush,
        input  stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl, bubble_count
    );

    // Issue stage side
    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_ctrl, wb_regwrite, wb_rd, wb_data, flush,
        output stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl, bubble_count
    );

endinterface

// File: rtl/id_ex_issue_load_use_detect.sv
// Load-use hazard detection: a load in execute whose destination is read by decode.
module load_use_detect
    import core_pkg::*;
(
    input  logic     ex_valid,
    input  logic     ex_memread,
    input  reg_idx_t ex_rd,
    input  logic     id_valid,
    input  reg_idx_t id_rs1,
    input  reg_idx_t id_rs2,
    output logic     hazard
);

    // x0 never carries a dependency, so a load to x0 cannot cause a hazard
    always_comb begin
        hazard = ex_valid && ex_memread && (ex_rd != '0) && id_valid &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue stage: write-back bypass, load-use bubble insertion, flush, pipeline register.
module id_ex_issue
    import core_pkg::*;
#(
    parameter int n = 32
)
(
    input  logic          clk,
    input  logic          reset,
    id_ex_issue_if.slave  bus
);

    logic           hazard;
    reg_idx_t       src_idx  [2];
    logic [n-1:0]   src_data [2];
    logic [n-1:0]   byp_data [2];

    logic           ex_valid_reg,    ex_valid_next;
    ctrl_t          ex_ctrl_reg,     ex_ctrl_next;
    logic [n-1:0]   ex_pc_reg,       ex_pc_next;
    logic [n-1:0]   ex_rs1_data_reg, ex_rs1_data_next;
    logic [n-1:0]   ex_rs2_data_reg, ex_rs2_data_next;
    logic [n-1:0]   ex_imm_reg,      ex_imm_next;
    reg_idx_t       ex_rs1_reg,      ex_rs1_next;
    reg_idx_t       ex_rs2_reg,      ex_rs2_next;
    reg_idx_t       ex_rd_reg,       ex_rd_next;
    logic [31:0]    bubble_count_reg, bubble_count_next;

    load_use_detect u_load_use_detect (
        .ex_valid   (ex_valid_reg),
        .ex_memread (ex_ctrl_reg[CTRL_MEMREAD]),
        .ex_rd      (ex_rd_reg),
        .id_valid   (bus.id_valid),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .hazard     (hazard)
    );

    assign src_idx[0]  = bus.id_rs1;
    assign src_idx[1]  = bus.id_rs2;
    assign src_data[0] = bus.id_rs1_data;
    assign src_data[1] = bus.id_rs2_data;

    // The register file only commits on the edge, so same-cycle write-back data is forwarded
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            assign byp_data[gi] = (src_idx[gi] == '0) ? '0 :
                                  wb_hits(bus.wb_regwrite, bus.wb_rd, src_idx[gi]) ? bus.wb_data :
                                  src_data[gi];
        end
    endgenerate

    // Stall only while actually stalling; flush discards the decode slot instead
    assign bus.stall = hazard && !bus.flush && !reset;

    // Next-state for ID/EX: flush and hazard both insert a bubble, otherwise capture decode
    always_comb begin
        ex_valid_next     = ex_valid_reg;
        ex_ctrl_next      = ex_ctrl_reg;
        ex_pc_next        = ex_pc_reg;
        ex_rs1_data_next  = ex_rs1_data_reg;
        ex_rs2_data_next  = ex_rs2_data_reg;
        ex_imm_next       = ex_imm_reg;
        ex_rs1_next       = ex_rs1_reg;
        ex_rs2_next       = ex_rs2_reg;
        ex_rd_next        = ex_rd_reg;
        bubble_count_next = bubble_count_reg;
        if (bus.flush) begin
            ex_valid_next = 1'b0;
            ex_ctrl_next  = CTRL_BUBBLE;
        end else if (hazard) begin
            ex_valid_next = 1'b0;
            ex_ctrl_next  = CTRL_BUBBLE;
            if (bubble_count_reg != '1) begin
                bubble_count_next = bubble_count_reg + 32'd1;
            end
        end else begin
            ex_valid_next    = bus.id_valid;
            // Keep ctrl zero for an invalid slot so execute never needs extra gating
            ex_ctrl_next     = bus.id_valid ? bus.id_ctrl : CTRL_BUBBLE;
            ex_pc_next       = bus.id_pc;
            ex_rs1_data_next = byp_data[0];
            ex_rs2_data_next = byp_data[1];
            ex_imm_next      = bus.id_imm;
            ex_rs1_next      = bus.id_rs1;
            ex_rs2_next      = bus.id_rs2;
            ex_rd_next       = bus.id_rd;
        end
    end

    // ID/EX pipeline register and bubble counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_reg     <= 1'b0;
            ex_ctrl_reg      <= CTRL_BUBBLE;
            ex_pc_reg        <= '0;
            ex_rs1_data_reg  <= '0;
            ex_rs2_data_reg  <= '0;
            ex_imm_reg       <= '0;
            ex_rs1_reg       <= '0;
            ex_rs2_reg       <= '0;
            ex_rd_reg        <= '0;
            bubble_count_reg <= '0;
        end else begin
            ex_valid_reg     <= ex_valid_next;
            ex_ctrl_reg      <= ex_ctrl_next;
            ex_pc_reg        <= ex_pc_next;
            ex_rs1_data_reg  <= ex_rs1_data_next;
            ex_rs2_data_reg  <= ex_rs2_data_next;
            ex_imm_reg       <= ex_imm_next;
            ex_rs1_reg       <= ex_rs1_next;
            ex_rs2_reg       <= ex_rs2_next;
            ex_rd_reg        <= ex_rd_next;
            bubble_count_reg <= bubble_count_next;
        end
    end

    assign bus.ex_valid     = ex_valid_reg;
    assign bus.ex_ctrl      = ex_ctrl_reg;
    assign bus.ex_pc        = ex_pc_reg;
    assign bus.ex_rs1_data  = ex_rs1_data_reg;
    assign bus.ex_rs2_data  = ex_rs2_data_reg;
    assign bus.ex_imm       = ex_imm_reg;
    assign bus.ex_rs1       = ex_rs1_reg;
    assign bus.ex_rs2       = ex_rs2_reg;
    assign bus.ex_rd        = ex_rd_reg;
    assign bus.bubble_count = bubble_count_reg;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed table-driven bench for id_ex_issue plus reset and saturation sequences.
module tb_id_ex_issue;
    import core_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    id_ex_issue_if #(.n(32)) bus ();

    id_ex_issue #(.n(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [7:0]  ctrl;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        fl;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_pc, e_d1, e_d2, e_imm;
        logic [7:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_rs1_data = 32'h1111;
        bus.id_rs2_data = 32'h2222;
        bus.id_imm      = 32'h0;
        bus.id_ctrl     = ctrl;
        bus.wb_regwrite = 1'b0;
        bus.wb_rd       = 5'd0;
        bus.wb_data     = 32'h0;
        bus.flush       = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"},    {31'd0, bus.stall},    32'd0);
        chk({tag, " ex_valid"}, {31'd0, bus.ex_valid}, 32'd0);
        chk({tag, " ex_ctrl"},  {24'd0, bus.ex_ctrl},  32'd0);
        chk({tag, " ex_pc"},    bus.ex_pc,             32'd0);
        chk({tag, " ex_rs1_data"}, bus.ex_rs1_data,    32'd0);
        chk({tag, " ex_rs2_data"}, bus.ex_rs2_data,    32'd0);
        chk({tag, " ex_imm"},   bus.ex_imm,            32'd0);
        chk({tag, " ex_idx"},   {17'd0, bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, 32'd0);
        chk({tag, " bubble_count"}, bus.bubble_count,  32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00);

        //         v  pc     rs1  rs2  rd   d1       d2       imm     ctrl   wbw wbrd wbd        fl  | st ev epc    ed1     ed2       eimm    ectrl  erd  ecnt
        vecs[0]  = '{1, 32'h10, 5'd1, 5'd2, 5'd4, 32'h5,  32'h6,  32'h20, 8'h11, 0, 5'd0, 32'h0,     0,  0, 1, 32'h10, 32'h5,  32'h6,    32'h20, 8'h11, 5'd4, 32'd0};
        vecs[1]  = '{1, 32'h14, 5'd1, 5'd3, 5'd5, 32'h7,  32'h1,  32'h0,  8'h01, 1, 5'd3, 32'hDEAD,  0,  0, 1, 32'h14, 32'h7,  32'hDEAD, 32'h0,  8'h01, 5'd5, 32'd0};
        vecs[2]  = '{1, 32'h18, 5'd2, 5'd0, 5'd6, 32'h9,  32'h1,  32'h4,  8'h01, 1, 5'd0, 32'hBEEF,  0,  0, 1, 32'h18, 32'h9,  32'h0,    32'h4,  8'h01, 5'd6, 32'd0};
        vecs[3]  = '{1, 32'h1C, 5'd6, 5'd2, 5'd6, 32'h33, 32'h2,  32'h8,  8'h01, 0, 5'd6, 32'h55,    0,  0, 1, 32'h1C, 32'h33, 32'h2,    32'h8,  8'h01, 5'd6, 32'd0};
        vecs[4]  = '{1, 32'h20, 5'd1, 5'd2, 5'd7, 32'h1,  32'h2,  32'hC,  8'h0B, 0, 5'd0, 32'h0,     0,  0, 1, 32'h20, 32'h1,  32'h2,    32'hC,  8'h0B, 5'd7, 32'd0};
        vecs[5]  = '{1, 32'h24, 5'd7, 5'd8, 5'd9, 32'hA,  32'hB,  32'h10, 8'h01, 0, 5'd0, 32'h0,     0,  1, 0, 32'h20, 32'h1,  32'h2,    32'hC,  8'h00, 5'd7, 32'd1};
        vecs[6]  = '{1, 32'h24, 5'd7, 5'd8, 5'd9, 32'hA,  32'hB,  32'h10, 8'h01, 0, 5'd0, 32'h0,     0,  0, 1, 32'h24, 32'hA,  32'hB,    32'h10, 8'h01, 5'd9, 32'd1};
        vecs[7]  = '{1, 32'h28, 5'd1, 5'd2, 5'd7, 32'h1,  32'h2,  32'hC,  8'h0B, 0, 5'd0, 32'h0,     0,  0, 1, 32'h28, 32'h1,  32'h2,    32'hC,  8'h0B, 5'd7, 32'd1};
        vecs[8]  = '{1, 32'h2C, 5'd8, 5'd7, 5'd9, 32'hA,  32'hB,  32'h10, 8'h01, 0, 5'd0, 32'h0,     1,  0, 0, 32'h28, 32'h1,  32'h2,    32'hC,  8'h00, 5'd7, 32'd1};
        vecs[9]  = '{1, 32'h30, 5'd1, 5'd2, 5'd7, 32'h3,  32'h4,  32'h14, 8'h0B, 0, 5'd0, 32'h0,     0,  0, 1, 32'h30, 32'h3,  32'h4,    32'h14, 8'h0B, 5'd7, 32'd1};
        vecs[10] = '{0, 32'h34, 5'd7, 5'd7, 5'd9, 32'hA,  32'hB,  32'h10, 8'h01, 0, 5'd0, 32'h0,     0,  0, 0, 32'h34, 32'hA,  32'hB,    32'h10, 8'h00, 5'd9, 32'd1};
        vecs[11] = '{1, 32'h38, 5'd1, 5'd2, 5'd0, 32'h1,  32'h2,  32'h0,  8'h0B, 0, 5'd0, 32'h0,     0,  0, 1, 32'h38, 32'h1,  32'h2,    32'h0,  8'h0B, 5'd0, 32'd1};
        vecs[12] = '{1, 32'h3C, 5'd0, 5'd0, 5'd3, 32'hA,  32'hB,  32'h0,  8'h01, 0, 5'd0, 32'h0,     0,  0, 1, 32'h3C, 32'h0,  32'h0,    32'h0,  8'h01, 5'd3, 32'd1};
        vecs[13] = '{1, 32'h40, 5'd3, 5'd1, 5'd4, 32'hC,  32'hD,  32'h0,  8'h01, 0, 5'd0, 32'h0,     0,  0, 1, 32'h40, 32'hC,  32'hD,    32'h0,  8'h01, 5'd4, 32'd1};
        vecs[14] = '{1, 32'h44, 5'd1, 5'd2, 5'd5, 32'h1,  32'h2,  32'h0,  8'h0B, 0, 5'd0, 32'h0,     0,  0, 1, 32'h44, 32'h1,  32'h2,    32'h0,  8'h0B, 5'd5, 32'd1};
        vecs[15] = '{1, 32'h48, 5'd1, 5'd5, 5'd6, 32'hE,  32'hF,  32'h0,  8'h01, 1, 5'd5, 32'h77,    0,  1, 0, 32'h44, 32'h1,  32'h2,    32'h0,  8'h00, 5'd5, 32'd2};
        vecs[16] = '{1, 32'h48, 5'd1, 5'd5, 5'd6, 32'hE,  32'hF,  32'h0,  8'h01, 1, 5'd5, 32'h77,    0,  0, 1, 32'h48, 32'hE,  32'h77,   32'h0,  8'h01, 5'd6, 32'd2};

        // Reset state, with a dependent-looking decode present
        drive(1'b1, 32'h99, 5'd7, 5'd7, 5'd7, 8'h0B);
        step();
        step();
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Table-driven vectors; state carries from one row to the next
        for (int i = 0; i < 17; i++) begin
            bus.id_valid    = vecs[i].v;
            bus.id_pc       = vecs[i].pc;
            bus.id_rs1      = vecs[i].rs1;
            bus.id_rs2      = vecs[i].rs2;
            bus.id_rd       = vecs[i].rd;
            bus.id_rs1_data = vecs[i].d1;
            bus.id_rs2_data = vecs[i].d2;
            bus.id_imm      = vecs[i].imm;
            bus.id_ctrl     = vecs[i].ctrl;
            bus.wb_regwrite = vecs[i].wbw;
            bus.wb_rd       = vecs[i].wbrd;
            bus.wb_data     = vecs[i].wbd;
            bus.flush       = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d stall", i), {31'd0, bus.stall}, {31'd0, vecs[i].e_stall});
            step();
            chk($sformatf("vec%0d ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d ex_pc", i), bus.ex_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d ex_rs1_data", i), bus.ex_rs1_data, vecs[i].e_d1);
            chk($sformatf("vec%0d ex_rs2_data", i), bus.ex_rs2_data, vecs[i].e_d2);
            chk($sformatf("vec%0d ex_imm", i), bus.ex_imm, vecs[i].e_imm);
            chk($sformatf("vec%0d ex_ctrl", i), {24'd0, bus.ex_ctrl}, {24'd0, vecs[i].e_ctrl});
            chk($sformatf("vec%0d ex_rd", i), {27'd0, bus.ex_rd}, {27'd0, vecs[i].e_rd});
            chk($sformatf("vec%0d bubble_count", i), bus.bubble_count, vecs[i].e_cnt);
            if (!vecs[i].e_stall && !vecs[i].fl) begin
                chk($sformatf("vec%0d ex_rs1", i), {27'd0, bus.ex_rs1}, {27'd0, vecs[i].rs1});
                chk($sformatf("vec%0d ex_rs2", i), {27'd0, bus.ex_rs2}, {27'd0, vecs[i].rs2});
            end
            $display("vec%0d pc=0x%0h stall=%0b ex_valid=%0b ex_ctrl=0x%02h count=%0d",
                     i, vecs[i].pc, vecs[i].e_stall, bus.ex_valid, bus.ex_ctrl, bus.bubble_count);
        end

        // Three more load-use bubbles: count 2 -> 5
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd7, 8'h0B);
            step();
            drive(1'b1, 32'h104, 5'd7, 5'd2, 5'd8, 8'h01);
            #1;
            chk($sformatf("lu%0d stall", k), {31'd0, bus.stall}, 32'd1);
            step();
            $display("lu%0d bubble_count=%0d", k, bus.bubble_count);
        end
        chk("lu bubble_count", bus.bubble_count, 32'd5);

        // Async reset mid-stall: valid load in EX, dependent decode, count 5
        drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd7, 8'h0B);
        step();
        drive(1'b1, 32'h204, 5'd7, 5'd7, 5'd8, 8'h01);
        #1;
        chk("pre-reset stall", {31'd0, bus.stall}, 32'd1);
        chk("pre-reset ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("async reset");
        $display("async reset applied between edges");
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Saturation: preload just below the ceiling, then two more load-use bubbles
        @(negedge clk);
        force dut.bubble_count_reg = 32'hFFFF_FFFE;
        step();
        release dut.bubble_count_reg;
        #1;
        chk("preload bubble_count", bus.bubble_count, 32'hFFFF_FFFE);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h300, 5'd1, 5'd2, 5'd9, 8'h0B);
            step();
            drive(1'b1, 32'h304, 5'd3, 5'd9, 5'd4, 8'h01);
            #1;
            chk($sformatf("sat%0d stall", k), {31'd0, bus.stall}, 32'd1);
            step();
            chk($sformatf("sat%0d bubble_count", k), bus.bubble_count, 32'hFFFF_FFFF);
            $display("sat%0d bubble_count=0x%08h", k, bus.bubble_count);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
